neo_io_ctrl: RTL

//  Clocked, parametrised successor of the F0 I/O controller.
//  - Decodes 68K byte writes ($38xx01, odd bytes) into slot select, LED latch/data and RTC control registers.
//  - Drives DIP, system-type and RTC status reads onto the 68K bus.
//  - Adds an LED strobe pulse generator and an optional RTC (uPD4990) serial command shifter.
//  - Sits between the 68K bus glue and the cart slots, LED drivers and RTC.

---
 rtl/neo_io_pkg.sv | 15 +
 rtl/neo_rtc_shifter.sv | 62 ++++++
 rtl/neo_io_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/neo_io_pkg.sv
// Shared constants and types for the Neo-Geo I/O controller.
package neo_io_pkg;
  localparam logic [2:0] ADDR_SLOT     = 3'b010;
  localparam logic [2:0] ADDR_LEDLATCH = 3'b011;
  localparam logic [2:0] ADDR_LEDDATA  = 3'b100;
  localparam logic [2:0] ADDR_RTCCTRL  = 3'b101;
  localparam logic [2:0] ADDR_RTCCMD   = 3'b110;

  typedef enum logic [2:0] {IDLE, DATA, CLKH, CLKL, STB} rtc_state_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } wr_req_t;
endpackage

// File: rtl/neo_rtc_shifter.sv
// uPD4990 serial command shifter: 4 bits LSB first, then a strobe phase.
// Used by neo_io_ctrl only when NEO_IO_RTC_SHIFTER_EN is defined.
module neo_rtc_shifter
  import neo_io_pkg::*;
#(
  parameter int RTC_HALF = 8
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       start,
  input  logic [3:0] cmd,
  output logic       rtc_din,
  output logic       rtc_clk,
  output logic       rtc_strobe,
  output logic       busy
);
  localparam int HW = (RTC_HALF > 1) ? $clog2(RTC_HALF) : 1;

  rtc_state_t    state, state_nx;
  logic [HW-1:0] hcnt;
  logic [1:0]    bitn;
  logic [3:0]    cmd_q;
  logic          half_done;

  assign half_done = (hcnt == HW'(RTC_HALF - 1));

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state <= IDLE;
      hcnt  <= '0;
      bitn  <= '0;
      cmd_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        hcnt <= '0;
        bitn <= '0;
        if (start) cmd_q <= cmd;
      end else begin
        hcnt <= half_done ? '0 : hcnt + 1'b1;
        if (half_done && state == CLKL) bitn <= bitn + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)     state_nx = DATA;
      DATA:    if (half_done) state_nx = CLKH;
      CLKH:    if (half_done) state_nx = CLKL;
      CLKL:    if (half_done) state_nx = (bitn == 2'd3) ? STB : DATA;
      STB:     if (half_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign rtc_clk    = (state == CLKH);
  assign rtc_strobe = (state == STB);
  assign rtc_din    = (state == DATA || state == CLKH || state == CLKL) && cmd_q[bitn];
endmodule

// File: rtl/neo_io_ctrl.sv
// Clocked I/O controller: 68K write decode, slot select, LED strobe, RTC pins, DIP/status reads.
// Define NEO_IO_RTC_SHIFTER_EN to add the RTC serial command shifter on the 110 address.
module neo_io_ctrl
  import neo_io_pkg::*;
#(
  parameter int         NUM_SLOTS     = 6,
  parameter int         SLOT_W        = 3,
  parameter int         LED_PULSE_CYC = 4,
  parameter int         RTC_HALF      = 8,
  parameter logic [7:0] SYSTYPE_VAL   = 8'hC0
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  input  logic                 nBITWD0,
  input  logic                 nDIPRD0,
  input  logic                 nDIPRD1,
  input  logic [3:0]           M68K_ADDR,
  input  logic [7:0]           M68K_DIN,
  output logic [7:0]           M68K_DOUT,
  output logic                 M68K_OE,
  input  logic [7:0]           DIPSW,
  input  logic                 SYSTEMB,
  output logic [NUM_SLOTS-1:0] nSLOT,
  output logic [SLOT_W-1:0]    SLOT_SEL,
  output logic [2:0]           LED_LATCH,
  output logic [7:0]           LED_DATA,
  output logic                 LED_STB,
  input  logic                 RTC_DOUT,
  input  logic                 RTC_TP,
  output logic                 RTC_DIN,
  output logic                 RTC_CLK,
  output logic                 RTC_STROBE,
  output logic                 RTC_BUSY
);
  localparam int PW = $clog2(LED_PULSE_CYC + 1);

  // [0],[1] synchronise the async strobe; [2] holds the previous level for edge detect
  logic [2:0]    wr_sync;
  logic          wr;
  wr_req_t       req;
  logic [SLOT_W-1:0] slot_q;
  logic [2:0]    rtcctrl;
  logic [PW-1:0] stb_cnt;
  logic          rtc_busy;

  assign req = '{sel: M68K_ADDR[2:0], data: M68K_DIN};

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      wr_sync <= '1;
      wr      <= 1'b0;
    end else begin
      wr_sync <= {wr_sync[1:0], nBITWD0};
      wr      <= wr_sync[2] & ~wr_sync[1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      slot_q    <= '0;
      LED_LATCH <= '0;
      LED_DATA  <= '0;
      rtcctrl   <= '0;
      stb_cnt   <= '0;
    end else begin
      if (stb_cnt != '0) stb_cnt <= stb_cnt - 1'b1;
      // a reload below overrides the decrement, so back-to-back LED writes extend the pulse
      if (wr) begin
        case (req.sel)
          ADDR_SLOT:     slot_q <= req.data[SLOT_W-1:0];
          ADDR_LEDLATCH: begin
            LED_LATCH <= req.data[5:3];
            stb_cnt   <= PW'(LED_PULSE_CYC);
          end
          ADDR_LEDDATA:  begin
            LED_DATA <= req.data;
            stb_cnt  <= PW'(LED_PULSE_CYC);
          end
          ADDR_RTCCTRL:  if (!rtc_busy) rtcctrl <= req.data[2:0];
          default: ;
        endcase
      end
    end
  end

  assign SLOT_SEL = slot_q;
  assign LED_STB  = (stb_cnt != '0);

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    always_ff @(posedge CLK) begin
      if (!nRESET) nSLOT[i] <= 1'b1;
      else         nSLOT[i] <= ~(SYSTEMB && slot_q == SLOT_W'(i));
    end
  end

`ifdef NEO_IO_RTC_SHIFTER_EN
  logic sh_din, sh_clk, sh_stb;

  neo_rtc_shifter #(.RTC_HALF(RTC_HALF)) u_rtc (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .start      (wr && req.sel == ADDR_RTCCMD && !rtc_busy),
    .cmd        (req.data[3:0]),
    .rtc_din    (sh_din),
    .rtc_clk    (sh_clk),
    .rtc_strobe (sh_stb),
    .busy       (rtc_busy)
  );

  assign RTC_DIN    = rtc_busy ? sh_din : rtcctrl[0];
  assign RTC_CLK    = rtc_busy ? sh_clk : rtcctrl[1];
  assign RTC_STROBE = rtc_busy ? sh_stb : rtcctrl[2];
`else
  assign rtc_busy   = 1'b0;
  assign RTC_DIN    = rtcctrl[0];
  assign RTC_CLK    = rtcctrl[1];
  assign RTC_STROBE = rtcctrl[2];
`endif
  assign RTC_BUSY = rtc_busy;

  always_comb begin
    M68K_DOUT = '0;
    if (!nDIPRD0)      M68K_DOUT = M68K_ADDR[3] ? SYSTYPE_VAL : DIPSW;
    else if (!nDIPRD1) M68K_DOUT = {RTC_DOUT, RTC_TP, 6'b111111};
  end
  assign M68K_OE = ~nDIPRD0 | ~nDIPRD1;
endmodule
